// File: rtl/score4_game_ctrl.sv
// Score 4 game-state engine: column cursor, piece drop, and a one-cell-per-cycle win/full scan.
// Optional build macro CURSOR_WRAP_EN makes the cursor wrap between columns 0 and 6.
module score4_game_ctrl #(
  parameter int START_COL    = 3,
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 left,
  input  logic                 right,
  input  logic                 put,
  output logic [6:0][5:0][1:0] panel,
  output logic [6:0]           play,
  output logic                 turn,
  output logic                 win,
  output logic [2:0]           winner_column,
  output logic [2:0]           winner_row,
  output logic [1:0]           winner_kind,
  output logic                 full
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   left_q, right_q, put_q;
  logic [2:0]             cur_q, cur_d;
  logic [6:0]             play_q, play_d;
  logic [6:0][5:0][1:0]   panel_q, panel_d;
  logic                   turn_q, turn_d;
  logic                   win_q, win_d;
  logic                   full_q, full_d;
  logic [2:0]             wcol_q, wcol_d;
  logic [2:0]             wrow_q, wrow_d;
  logic [1:0]             wkind_q, wkind_d;
  logic [2:0]             scol_q, scol_d;
  logic [2:0]             srow_q, srow_d;

  logic                   left_rise, right_rise, put_rise;
  logic [1:0]             scan_code;
  logic [3:0]             hit;
  logic [41:0]            occ;
  logic                   board_full;
  logic                   drop_ok;
  logic [2:0]             drop_row;

  // Four cells starting at (c0,r0) stepping (dc,dr); any cell off the board is a miss.
  function automatic logic line_hit(input logic [6:0][5:0][1:0] b, input logic [1:0] code,
                                    input int c0, input int r0, input int dc, input int dr);
    logic h;
    int   c;
    int   r;
    h = 1'b1;
    for (int k = 0; k < 4; k++) begin
      c = c0 + dc * k;
      r = r0 + dr * k;
      if (c < 0 || c > 6 || r < 0 || r > 5) h = 1'b0;
      else if (b[c[2:0]][r[2:0]] != code) h = 1'b0;
    end
    return h;
  endfunction

  assign left_rise  = left & ~left_q;
  assign right_rise = right & ~right_q;
  assign put_rise   = put & ~put_q;
  assign scan_code  = {turn_q, ~turn_q};

  for (genvar gi = 0; gi < 4; gi++) begin : g_kind
    localparam int DC = (gi == 1) ? 0 : ((gi == 3) ? -1 : 1);
    localparam int DR = (gi == 0) ? 0 : 1;
    assign hit[gi] = line_hit(panel_q, scan_code, int'(scol_q), int'(srow_q), DC, DR);
  end

  for (genvar gi = 0; gi < 42; gi++) begin : g_occ
    assign occ[gi] = |panel_q[gi / 6][gi % 6];
  end
  assign board_full = &occ;

  always_comb begin
    drop_ok  = 1'b0;
    drop_row = 3'd0;
    // Walk top-down so the last empty cell seen is the lowest one.
    for (int r = 5; r >= 0; r--) begin
      if (panel_q[cur_q][r[2:0]] == 2'b00) begin
        drop_ok  = 1'b1;
        drop_row = r[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    panel_d = panel_q;
    turn_d  = turn_q;
    win_d   = win_q;
    full_d  = full_q;
    wcol_d  = wcol_q;
    wrow_d  = wrow_q;
    wkind_d = wkind_q;
    scol_d  = scol_q;
    srow_d  = srow_q;
    case (state_q)
      IDLE: begin
        if (put_rise) begin
          if (drop_ok) begin
            panel_d[cur_q][drop_row] = scan_code;
            scol_d  = 3'd0;
            srow_d  = 3'd0;
            state_d = SCAN;
          end
        end else if (left_rise && !right_rise) begin
          if (cur_q == 3'd0) begin
`ifdef CURSOR_WRAP_EN
            cur_d = 3'd6;
`endif
          end else begin
            cur_d = cur_q - 3'd1;
          end
        end else if (right_rise && !left_rise) begin
          if (cur_q == 3'd6) begin
`ifdef CURSOR_WRAP_EN
            cur_d = 3'd0;
`endif
          end else begin
            cur_d = cur_q + 3'd1;
          end
        end
      end
      SCAN: begin
        if (|hit) begin
          win_d   = 1'b1;
          wcol_d  = scol_q;
          wrow_d  = srow_q;
          wkind_d = hit[0] ? 2'd0 : (hit[1] ? 2'd1 : (hit[2] ? 2'd2 : 2'd3));
          state_d = DONE;
        end else if (scol_q == 3'd6 && srow_q == 3'd5) begin
          if (board_full) begin
            full_d  = 1'b1;
            state_d = DONE;
          end else begin
            turn_d  = ~turn_q;
            state_d = IDLE;
          end
        end else if (srow_q == 3'd5) begin
          srow_d = 3'd0;
          scol_d = scol_q + 3'd1;
        end else begin
          srow_d = srow_q + 3'd1;
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase
    play_d = 7'b0000001 << cur_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      left_q  <= 1'b0;
      right_q <= 1'b0;
      put_q   <= 1'b0;
      cur_q   <= 3'(START_COL);
      play_q  <= 7'b0000001 << START_COL;
      panel_q <= '0;
      turn_q  <= FIRST_PLAYER;
      win_q   <= 1'b0;
      full_q  <= 1'b0;
      wcol_q  <= 3'd0;
      wrow_q  <= 3'd0;
      wkind_q <= 2'd0;
      scol_q  <= 3'd0;
      srow_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      left_q  <= left;
      right_q <= right;
      put_q   <= put;
      cur_q   <= cur_d;
      play_q  <= play_d;
      panel_q <= panel_d;
      turn_q  <= turn_d;
      win_q   <= win_d;
      full_q  <= full_d;
      wcol_q  <= wcol_d;
      wrow_q  <= wrow_d;
      wkind_q <= wkind_d;
      scol_q  <= scol_d;
      srow_q  <= srow_d;
    end
  end

  assign panel         = panel_q;
  assign play          = play_q;
  assign turn          = turn_q;
  assign win           = win_q;
  assign full          = full_q;
  assign winner_column = wcol_q;
  assign winner_row    = wrow_q;
  assign winner_kind   = wkind_q;

endmodule

// File: tb/tb_score4_game_ctrl.sv
// Self-checking bench for score4_game_ctrl: directed games plus random play against a board model.
module tb_score4_game_ctrl;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 left = 1'b0;
  logic                 right = 1'b0;
  logic                 put = 1'b0;
  logic [6:0][5:0][1:0] panel;
  logic [6:0]           play;
  logic                 turn;
  logic                 win;
  logic [2:0]           winner_column;
  logic [2:0]           winner_row;
  logic [1:0]           winner_kind;
  logic                 full;

  score4_game_ctrl dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
    .panel(panel), .play(play), .turn(turn), .win(win),
    .winner_column(winner_column), .winner_row(winner_row),
    .winner_kind(winner_kind), .full(full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int bd[7][6];
  int m_cur, m_turn, m_wc, m_wr, m_wk;
  bit m_win, m_full, m_done;
  bit p_found;
  int p_k, p_wc, p_wr, p_wk;
  int dcs[4] = '{1, 0, 1, -1};
  int drs[4] = '{0, 1, 1, 1};

  int seq_v[7]  = '{3, 4, 3, 4, 3, 4, 3};
  int seq_h[7]  = '{0, 6, 1, 6, 2, 6, 3};
  int seq_d[11] = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [83:0] obs, input logic [83:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [83:0] exp_panel();
    logic [83:0] v;
    v = '0;
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        v[(c * 6 + r) * 2 +: 2] = 2'(bd[c][r]);
    return v;
  endfunction

  function automatic bit m_board_full();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        if (bd[c][r] == 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++)
        bd[c][r] = 0;
    m_cur = 3; m_turn = 0;
    m_win = 0; m_full = 0; m_done = 0;
    m_wc = 0; m_wr = 0; m_wk = 0;
  endtask

  // Scan order: column-major, bottom-up; first cell with any line wins, kinds in order 0..3.
  task automatic m_scan();
    int code, c, r;
    bit ok;
    code = m_turn + 1;
    p_found = 0;
    for (int idx = 0; idx < 42 && !p_found; idx++) begin
      for (int kd = 0; kd < 4 && !p_found; kd++) begin
        ok = 1;
        for (int s = 0; s < 4; s++) begin
          c = idx / 6 + dcs[kd] * s;
          r = idx % 6 + drs[kd] * s;
          if (c < 0 || c > 6 || r < 0 || r > 5) ok = 0;
          else if (bd[c][r] != code) ok = 0;
        end
        if (ok) begin
          p_found = 1; p_k = idx; p_wc = idx / 6; p_wr = idx % 6; p_wk = kd;
        end
      end
    end
  endtask

  task automatic m_drop(output bit acc);
    int row;
    acc = 0;
    row = -1;
    if (m_done) return;
    for (int r = 5; r >= 0; r--)
      if (bd[m_cur][r] == 0) row = r;
    if (row < 0) return;
    bd[m_cur][row] = m_turn + 1;
    m_scan();
    acc = 1;
  endtask

  task automatic m_commit();
    if (p_found) begin
      m_win = 1; m_done = 1; m_wc = p_wc; m_wr = p_wr; m_wk = p_wk;
    end else if (m_board_full()) begin
      m_full = 1; m_done = 1;
    end else begin
      m_turn ^= 1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_panel"}, panel, exp_panel());
    chk({tag, "_play"}, play, 7'b0000001 << m_cur);
    chk({tag, "_turn"}, turn, m_turn);
    chk({tag, "_win"}, win, m_win);
    chk({tag, "_full"}, full, m_full);
    chk({tag, "_wcol"}, winner_column, m_wc);
    chk({tag, "_wrow"}, winner_row, m_wr);
    chk({tag, "_wkind"}, winner_kind, m_wk);
  endtask

  task automatic do_reset();
    rst = 1'b0; left = 1'b0; right = 1'b0; put = 1'b0;
    tick(); tick();
    m_reset();
    check_all("reset");
    rst = 1'b1;
    tick();
  endtask

  task automatic press_lr(input bit l, input bit r);
    left = l; right = r;
    tick();
    left = 1'b0; right = 1'b0;
    tick();
    if (!m_done) begin
      if (l && !r) begin
        if (m_cur > 0) m_cur--;
`ifdef CURSOR_WRAP_EN
        else m_cur = 6;
`endif
      end else if (r && !l) begin
        if (m_cur < 6) m_cur++;
`ifdef CURSOR_WRAP_EN
        else m_cur = 0;
`endif
      end
    end
    chk("move_play", play, 7'b0000001 << m_cur);
    $display("move l=%0b r=%0b play=%b", l, r, play);
  endtask

  task automatic goto(input int col);
    while (m_cur < col) press_lr(1'b0, 1'b1);
    while (m_cur > col) press_lr(1'b1, 1'b0);
  endtask

  task automatic do_put();
    bit acc;
    int old_turn, lat;
    old_turn = m_turn;
    put = 1'b1;
    tick();
    put = 1'b0;
    m_drop(acc);
    if (!acc) begin
      tick();
      check_all("put_ignored");
      $display("put col=%0d ignored", m_cur);
      return;
    end
    chk("put_write", panel, exp_panel());
    lat = p_found ? p_k + 1 : 42;
    repeat (lat - 1) tick();
    chk("pre_win", win, 1'b0);
    chk("pre_full", full, 1'b0);
    chk("pre_turn", turn, old_turn);
    tick();
    m_commit();
    check_all("scan_result");
    $display("put col=%0d lat=%0d win=%0b full=%0b turn=%0b", m_cur, lat, win, full, turn);
  endtask

  task automatic drop_at(input int col);
    goto(col);
    do_put();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    bit acc;
    int op;

    // Reset state and cursor movement
    do_reset();
    chk("reset_play_const", play, 7'b0001000);
    for (int i = 0; i < 3; i++) press_lr(1'b0, 1'b1);
    chk("play_col6", play, 7'b1000000);
    press_lr(1'b0, 1'b1);
`ifdef CURSOR_WRAP_EN
    chk("play_edge_right", play, 7'b0000001);
`else
    chk("play_edge_right", play, 7'b1000000);
`endif
    press_lr(1'b0, 1'b1);
    press_lr(1'b1, 1'b0);
    press_lr(1'b1, 1'b1);
    goto(0);
    press_lr(1'b1, 1'b0);

    // Vertical win in column 3
    do_reset();
    foreach (seq_v[i]) drop_at(seq_v[i]);
    chk("v_win", win, 1'b1);
    chk("v_kind", winner_kind, 2'd1);
    chk("v_col", winner_column, 3'd3);
    chk("v_row", winner_row, 3'd0);
    chk("v_turn", turn, 1'b0);
    chk("v_col4", {panel[4][2], panel[4][1], panel[4][0]}, 6'b101010);
    // DONE ignores every button
    press_lr(1'b1, 1'b0);
    do_put();

    // Horizontal win on the bottom row
    do_reset();
    foreach (seq_h[i]) drop_at(seq_h[i]);
    chk("h_win", win, 1'b1);
    chk("h_kind", winner_kind, 2'd0);
    chk("h_col", winner_column, 3'd0);
    chk("h_row", winner_row, 3'd0);

    // Full column, held put, and a put rise during the scan
    do_reset();
    for (int i = 0; i < 6; i++) drop_at(2);
    do_put();
    chk("colfull_turn", turn, 1'b0);
    press_lr(1'b0, 1'b1);
    put = 1'b1;
    tick();
    m_drop(acc);
    repeat (99) tick();
    put = 1'b0;
    tick();
    if (acc) m_commit();
    check_all("hold_put");
    $display("hold put col=%0d turn=%0b", m_cur, turn);
    press_lr(1'b0, 1'b1);
    put = 1'b1;
    tick();
    put = 1'b0;
    m_drop(acc);
    repeat (3) tick();
    put = 1'b1;
    tick();
    put = 1'b0;
    repeat (38) tick();
    if (acc) m_commit();
    check_all("scan_rise");
    tick();
    check_all("after_scan");
    $display("put during scan col=%0d turn=%0b", m_cur, turn);

    // Diagonal win, then reset in the middle of the next scan
    do_reset();
    foreach (seq_d[i]) drop_at(seq_d[i]);
    chk("d_win", win, 1'b1);
    chk("d_kind", winner_kind, 2'd2);
    chk("d_col", winner_column, 3'd0);
    chk("d_row", winner_row, 3'd0);
    do_reset();
    put = 1'b1;
    tick();
    put = 1'b0;
    m_drop(acc);
    repeat (10) tick();
    #2;
    rst = 1'b0;
    #1;
    m_reset();
    check_all("async_rst");
    $display("async reset mid-scan play=%b turn=%0b", play, turn);
    tick();
    rst = 1'b1;
    tick();

    // Random play
    for (int i = 0; i < 150; i++) begin
      if (m_done) do_reset();
      op = $urandom_range(0, 5);
      case (op)
        0: press_lr(1'b1, 1'b0);
        1: press_lr(1'b0, 1'b1);
        2: press_lr(1'b1, 1'b1);
        default: do_put();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
